// File: rtl/alu_core_param.sv
// Handshaked ALU core: single-cycle arithmetic/logic ops, plus iterative
// shift-add multiply and restoring divide/modulo that take WIDTH cycles.
module alu_core_param #(
  parameter int WIDTH     = 8,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [3:0]       operator,
  output logic             calculated,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             error
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state;
  logic [SW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [SW-1:0]    w_shamt;
  logic [SW-1:0]    w_negShamt;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_asr;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_err;
  logic             w_iter;

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_remShift;
  logic             w_geq;
  logic [WIDTH-1:0] w_remSub;
  logic [WIDTH-1:0] w_nextHi;
  logic [WIDTH-1:0] w_nextLo;
  logic [WIDTH-1:0] w_finalRes;

  assign ready = reset_n && (r_state == IDLE) && (!calculated || result_ready);

  assign w_sum   = {1'b0, input_a} + {1'b0, input_b};
  assign w_diff  = {1'b0, input_a} - {1'b0, input_b};
  assign w_inc   = {1'b0, input_a} + (WIDTH+1)'(1);
  assign w_dec   = {1'b0, input_a} - (WIDTH+1)'(1);
  assign w_shamt = input_b[SW-1:0];

  // Rotating left by s equals (a<<s)|(a>>(-s mod WIDTH)); s=0 degenerates to a|a.
  assign w_negShamt = '0 - w_shamt;
  assign w_rol      = (input_a << w_shamt) | (input_a >> w_negShamt);
  assign w_asr      = $unsigned($signed(input_a) >>> w_shamt);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    w_iter  = 1'b0;
    case (operator)
      4'd0: begin
        w_res   = w_sum[MSB:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (input_a[MSB] == input_b[MSB]) && (w_sum[MSB] != input_a[MSB]);
      end
      4'd1: begin
        w_res   = w_diff[MSB:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (input_a[MSB] != input_b[MSB]) && (w_diff[MSB] != input_a[MSB]);
      end
      4'd2: w_res = input_a & input_b;
      4'd3: w_res = input_a | input_b;
      4'd4: w_res = input_a ^ input_b;
      4'd5: w_res = ~input_a;
      4'd6: w_res = input_a << w_shamt;
      4'd7: w_res = input_a >> w_shamt;
      4'd8: w_res = w_asr;
      4'd9: w_res = w_rol;
      4'd10: begin
        w_res   = w_inc[MSB:0];
        w_carry = w_inc[WIDTH];
        w_ovf   = !input_a[MSB] && w_inc[MSB];
      end
      4'd11: begin
        w_res   = w_dec[MSB:0];
        w_carry = w_dec[WIDTH];
        w_ovf   = input_a[MSB] && !w_dec[MSB];
      end
      4'd12: begin
        if (MULDIV_EN) w_iter = 1'b1;
        else           w_err  = 1'b1;
      end
      4'd13, 4'd14: begin
        if (!MULDIV_EN) begin
          w_err = 1'b1;
        end else if (input_b == '0) begin
          w_err = 1'b1;
          w_res = (operator == 4'd13) ? '1 : input_a;
        end else begin
          w_iter = 1'b1;
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  // Multiply keeps {hi,lo} as the shifting partial product; divide keeps
  // hi as the running remainder and lo as dividend-in / quotient-out.
  assign w_addend   = r_lo[0] ? r_b : '0;
  assign w_mulSum   = {1'b0, r_hi} + {1'b0, w_addend};
  assign w_remShift = {r_hi, r_lo[MSB]};
  assign w_geq      = w_remShift >= {1'b0, r_b};
  assign w_remSub   = w_remShift[MSB:0] - r_b;

  always_comb begin
    if (r_op == 2'b00) begin
      w_nextHi = w_mulSum[WIDTH:1];
      w_nextLo = {w_mulSum[0], r_lo[MSB:1]};
    end else begin
      w_nextHi = w_geq ? w_remSub : w_remShift[MSB:0];
      w_nextLo = {r_lo[MSB-1:0], w_geq};
    end
  end

  assign w_finalRes = (r_op == 2'b10) ? w_nextHi : w_nextLo;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_b        <= '0;
      r_op       <= '0;
      calculated <= 1'b0;
      result     <= '0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (calculated && result_ready) calculated <= 1'b0;
          if (start && ready) begin
            if (w_iter) begin
              r_state <= BUSY;
              r_count <= '0;
              r_hi    <= '0;
              r_lo    <= input_a;
              r_b     <= input_b;
              r_op    <= operator[1:0];
            end else begin
              calculated <= 1'b1;
              result     <= w_res;
              carry      <= w_carry;
              zero       <= (w_res == '0);
              overflow   <= w_ovf;
              error      <= w_err;
            end
          end
        end
        BUSY: begin
          r_hi    <= w_nextHi;
          r_lo    <= w_nextLo;
          r_count <= r_count + SW'(1);
          if (r_count == LAST) begin
            r_state    <= IDLE;
            calculated <= 1'b1;
            result     <= w_finalRes;
            carry      <= (r_op == 2'b00) && (|w_nextHi);
            zero       <= (w_finalRes == '0);
            overflow   <= 1'b0;
            error      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_core_param.sv
// Scoreboard bench for alu_core_param: a WIDTH=8 core with mul/div enabled,
// and a WIDTH=16 core with mul/div disabled.
module tb_alu_core_param;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        ready;
  logic [7:0]  input_a;
  logic [7:0]  input_b;
  logic [3:0]  operator;
  logic        calculated;
  logic        result_ready;
  logic [7:0]  result;
  logic        carry;
  logic        zero;
  logic        overflow;
  logic        error;

  logic        altStart;
  logic        altReady;
  logic [15:0] altA;
  logic [15:0] altB;
  logic [3:0]  altOp;
  logic        altCalc;
  logic        altResultReady;
  logic [15:0] altResult;
  logic        altCarry;
  logic        altZero;
  logic        altOverflow;
  logic        altError;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       v;
    logic       e;
    int         firstCycle;
  } expect_t;

  expect_t sbQueue[$];

  alu_core_param #(.WIDTH(8), .MULDIV_EN(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .ready(ready),
    .input_a(input_a), .input_b(input_b), .operator(operator),
    .calculated(calculated), .result_ready(result_ready), .result(result),
    .carry(carry), .zero(zero), .overflow(overflow), .error(error)
  );

  alu_core_param #(.WIDTH(16), .MULDIV_EN(1'b0)) altDut (
    .clock(clock), .reset_n(reset_n), .start(altStart), .ready(altReady),
    .input_a(altA), .input_b(altB), .operator(altOp),
    .calculated(altCalc), .result_ready(altResultReady), .result(altResult),
    .carry(altCarry), .zero(altZero), .overflow(altOverflow), .error(altError)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cycle++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a new result appears when calculated rises or is refilled
  // at a consuming edge; every consumed result is checked against the queue.
  initial begin
    int      firstSeen;
    logic    prevCalc;
    logic    prevConsumed;
    expect_t item;
    firstSeen    = 0;
    prevCalc     = 1'b0;
    prevConsumed = 1'b0;
    forever begin
      @(negedge clock);
      if (calculated && (!prevCalc || prevConsumed)) firstSeen = cycle;
      if (calculated && result_ready) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected result", 64'(result), 64'(0));
          checkOutput("unexpected result present", 64'(1), 64'(0));
        end else begin
          item = sbQueue.pop_front();
          checkOutput({item.name, " result/flags"},
                      64'({result, carry, zero, overflow, error}),
                      64'({item.res, item.c, item.z, item.v, item.e}));
          checkOutput({item.name, " latency"}, 64'(firstSeen), 64'(item.firstCycle));
        end
      end
      prevCalc     = calculated;
      prevConsumed = calculated && result_ready;
    end
  end

  task automatic applyStimulus(input string name, input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] op, input logic [7:0] eRes,
                               input logic eC, input logic eZ, input logic eV, input logic eE,
                               input bit iter);
    expect_t item;
    int      waitCount;
    input_a   = a;
    input_b   = b;
    operator  = op;
    start     = 1'b1;
    waitCount = 0;
    @(negedge clock);
    while (!ready && waitCount < 50) begin
      @(negedge clock);
      waitCount++;
    end
    if (!ready) begin
      checkOutput({name, " accept timeout"}, 64'(ready), 64'(1));
    end else begin
      item.name       = name;
      item.res        = eRes;
      item.c          = eC;
      item.z          = eZ;
      item.v          = eV;
      item.e          = eE;
      item.firstCycle = cycle + 1 + (iter ? 8 : 0);
      sbQueue.push_back(item);
    end
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic applyStimulusAlt(input string name, input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] op, input logic [15:0] eRes, input logic eE);
    altA     = a;
    altB     = b;
    altOp    = op;
    altStart = 1'b1;
    @(negedge clock);
    checkOutput({name, " ready"}, 64'(altReady), 64'(1));
    @(posedge clock);
    #1;
    altStart = 1'b0;
    @(negedge clock);
    checkOutput({name, " result/flags"},
                64'({altCalc, altResult, altCarry, altZero, altOverflow, altError}),
                64'({1'b1, eRes, 1'b0, (eRes == 16'h0), 1'b0, eE}));
  endtask

  initial begin
    int pulses;
    pulses         = 0;
    reset_n        = 1'b1;
    start          = 1'b0;
    input_a        = '0;
    input_b        = '0;
    operator       = '0;
    result_ready   = 1'b1;
    altStart       = 1'b0;
    altA           = '0;
    altB           = '0;
    altOp          = '0;
    altResultReady = 1'b1;

    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset outputs", 64'({calculated, result, carry, zero, overflow, error, ready}), 64'(0));
    checkOutput("alt reset outputs", 64'({altCalc, altResult, altError, altReady}), 64'(0));
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    checkOutput("ready after reset", 64'(ready), 64'(1));
    checkOutput("alt ready after reset", 64'(altReady), 64'(1));
    @(posedge clock);
    #1;

    applyStimulus("ADD 200+100", 8'd200, 8'd100, 4'd0, 8'h2C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("SUB 80-01",   8'h80,  8'h01,  4'd1, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back single-cycle ops with result_ready held high.
    applyStimulus("AND",       8'hCC, 8'hAA, 4'd2,  8'h88, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("OR",        8'hCC, 8'hAA, 4'd3,  8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("XOR zero",  8'h55, 8'h55, 4'd4,  8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("NOT",       8'h0F, 8'h33, 4'd5,  8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("SHL by 9",  8'h81, 8'd9,  4'd6,  8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("SHR by 3",  8'h81, 8'd3,  4'd7,  8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("ASR by 3",  8'h80, 8'd3,  4'd8,  8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("ROL by 1",  8'h81, 8'd1,  4'd9,  8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("INC FF",    8'hFF, 8'h00, 4'd10, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("INC 7F",    8'h7F, 8'h00, 4'd10, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("DEC 00",    8'h00, 8'h00, 4'd11, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("DEC 80",    8'h80, 8'h00, 4'd11, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("op15",      8'h12, 8'h34, 4'd15, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    applyStimulus("MUL 15*17", 8'd15, 8'd17, 4'd12, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checkOutput($sformatf("MUL busy ready cycle %0d", i), 64'(ready), 64'(0));
    end
    @(posedge clock);
    #1;
    applyStimulus("MUL 16*16", 8'd16, 8'd16, 4'd12, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus("DIV 200/7", 8'd200, 8'd7, 4'd13, 8'd28, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("MOD 200%7", 8'd200, 8'd7, 4'd14, 8'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("DIV 5/0",   8'd5,   8'd0, 4'd13, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("MOD 5/0",   8'd5,   8'd0, 4'd14, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure: result held while the consumer stalls; new start ignored.
    repeat (2) @(posedge clock);
    #1;
    result_ready = 1'b0;
    applyStimulus("ADD 1+2 held", 8'd1, 8'd2, 4'd0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    input_a  = 8'd9;
    input_b  = 8'd9;
    operator = 4'd0;
    start    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput($sformatf("hold cycle %0d", i),
                  64'({calculated, result, ready}), 64'({1'b1, 8'd3, 1'b0}));
    end
    @(posedge clock);
    #1;
    result_ready = 1'b1;
    applyStimulus("XOR F0^FF", 8'hF0, 8'hFF, 4'd4, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of an iterative multiply.
    applyStimulus("MUL 3*4", 8'd3, 8'd4, 4'd12, 8'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("mid-op reset outputs",
                64'({calculated, result, carry, zero, overflow, error, ready}), 64'(0));
    sbQueue.delete();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    checkOutput("ready after mid-op reset", 64'({ready, calculated}), 64'({1'b1, 1'b0}));
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (calculated) pulses++;
    end
    checkOutput("no calculated after reset", 64'(pulses), 64'(0));
    @(posedge clock);
    #1;
    applyStimulus("ADD 1+1", 8'd1, 8'd1, 4'd0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    @(posedge clock);
    #1;
    applyStimulusAlt("alt op12 disabled", 16'd3,     16'd4,  4'd12, 16'h0000, 1'b1);
    applyStimulusAlt("alt op13 disabled", 16'd200,   16'd7,  4'd13, 16'h0000, 1'b1);
    applyStimulusAlt("alt op15",          16'h1234,  16'd1,  4'd15, 16'h0000, 1'b1);
    applyStimulusAlt("alt ROL 8001 by 17", 16'h8001, 16'd17, 4'd9,  16'h0003, 1'b0);

    repeat (4) @(negedge clock);
    checkOutput("scoreboard drained", 64'(sbQueue.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
